// File: rtl/demux_reg_if.sv
// ============================================================================
//  Module      : demux_reg_if
//  Description : Bundles the stream and channel signals of demux_reg.
//                The slave modport is the demultiplexer's view. The master
//                modport is the view of the environment around it, which
//                acts as both the source and the two consumers.
//  Signals     : I/S/in_valid/in_ready - input stream with destination select
//                Y0/y0_valid/y0_ready  - channel 0 output
//                Y1/y1_valid/y1_ready  - channel 1 output
//                cnt0/cnt1             - per-channel accepted-word counters
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux_reg_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);

  logic [WIDTH-1:0] I;
  logic             S;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] Y0;
  logic             y0_valid;
  logic             y0_ready;

  logic [WIDTH-1:0] Y1;
  logic             y1_valid;
  logic             y1_ready;

  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Environment side: drives the input stream and the consumer readies.
  modport master (
    output I, S, in_valid, y0_ready, y1_ready,
    input  in_ready, Y0, Y1, y0_valid, y1_valid, cnt0, cnt1
  );

  // Demultiplexer side.
  modport slave (
    input  I, S, in_valid, y0_ready, y1_ready,
    output in_ready, Y0, Y1, y0_valid, y1_valid, cnt0, cnt1
  );

endinterface

`default_nettype wire

// File: rtl/demux_reg.sv
// ============================================================================
//  Module      : demux_reg
//  Description : Registered 1-to-2 demultiplexer. It steers each word of a
//                valid/ready input stream into one of two independently
//                back-pressured output registers, chosen by the select S.
//                Each channel holds one word and counts the words accepted
//                into it. The counters wrap.
//  Ports       : clk - rising-edge clock
//                rst - synchronous active-high reset
//                bus - demux_reg_if.slave, which carries:
//                        I, S, in_valid, in_ready   - input stream
//                        Y0/Y1, y0/y1_valid, ready  - output channels
//                        cnt0, cnt1                 - accept counters
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  demux_reg_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Per-channel views. Index 0 is Y0 and index 1 is Y1.
  logic [1:0]            w_yready;
  logic [1:0]            w_valid;
  logic [1:0]            w_free;
  logic [1:0]            w_load;
  logic [1:0][WIDTH-1:0] w_data;
  logic [1:0][CNT_W-1:0] w_cnt;
  logic                  w_in_ready;
  logic                  w_accept;

  assign w_yready = {bus.y1_ready, bus.y0_ready};

  // in_ready looks only at the slot named by the presented select.
  // in_valid is deliberately left out, so that a source cannot form a
  // combinational loop through in_ready. rst forces in_ready low so that no
  // word is reported as taken on a cycle whose edge discards it.
  assign w_in_ready = !rst && w_free[bus.S];
  assign w_accept   = bus.in_valid && w_in_ready;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_data;
      logic [CNT_W-1:0] r_cnt;
      logic             w_drain;

      assign w_valid[g] = (r_state == ST_FULL);
      assign w_drain    = w_valid[g] && w_yready[g];
      // The slot is free when it is empty, or when it empties at this edge.
      // A word that drains can be replaced by a new word in the same cycle.
      assign w_free[g]  = !w_valid[g] || w_yready[g];
      assign w_load[g]  = w_accept && (bus.S == 1'(g));

      always_comb begin
        w_state_nxt = r_state;
        case (r_state)
          ST_EMPTY: begin
            if (w_load[g]) begin
              w_state_nxt = ST_FULL;
            end
          end
          ST_FULL: begin
            // A drain together with a load keeps the slot full.
            if (w_drain && !w_load[g]) begin
              w_state_nxt = ST_EMPTY;
            end
          end
          default: begin
            w_state_nxt = ST_EMPTY;
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= ST_EMPTY;
          r_data  <= '0;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          // The data register only changes on a load. After a drain it
          // keeps showing the last word it held.
          if (w_load[g]) begin
            r_data <= bus.I;
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_data[g] = r_data;
      assign w_cnt[g]  = r_cnt;
    end
  endgenerate

  assign bus.in_ready = w_in_ready;
  assign bus.Y0       = w_data[0];
  assign bus.Y1       = w_data[1];
  assign bus.y0_valid = w_valid[0];
  assign bus.y1_valid = w_valid[1];
  assign bus.cnt0     = w_cnt[0];
  assign bus.cnt1     = w_cnt[1];

endmodule

`default_nettype wire

// File: tb/tb_demux_reg.sv
// ============================================================================
//  Module      : tb_demux_reg
//  Description : Directed self-checking bench for demux_reg.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_reg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;

  int n_total = 0;
  int n_bad   = 0;

  demux_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bif ();

  demux_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
    bif.in_valid = v;
    bif.S        = s;
    bif.I        = d;
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bif.I        = '0;
    bif.S        = 1'b0;
    bif.in_valid = 1'b0;
    bif.y0_ready = 1'b0;
    bif.y1_ready = 1'b0;

    // ---------------- reset, then idle ----------------
    step();
    chk("in_ready_in_rst", 32'(bif.in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_y0_valid", 32'(bif.y0_valid), 32'd0);
    chk("rst_y1_valid", 32'(bif.y1_valid), 32'd0);
    chk("rst_cnt0",     32'(bif.cnt0),     32'd0);
    chk("rst_cnt1",     32'(bif.cnt1),     32'd0);
    chk("rst_Y0",       32'(bif.Y0),       32'h0);
    chk("rst_Y1",       32'(bif.Y1),       32'h0);
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);

    // ---------------- steering, both consumers ready ----------------
    bif.y0_ready = 1'b1;
    bif.y1_ready = 1'b1;
    drive(1'b1, 1'b0, 16'h00AF);
    chk("steer_rdy0", 32'(bif.in_ready), 32'd1);
    step();
    chk("steer_Y0",       32'(bif.Y0),       32'h00AF);
    chk("steer_y0_valid", 32'(bif.y0_valid), 32'd1);
    chk("steer_cnt0",     32'(bif.cnt0),     32'd1);
    chk("steer_y1_idle",  32'(bif.y1_valid), 32'd0);
    drive(1'b1, 1'b1, 16'h00FA);
    step();
    chk("steer_Y1",       32'(bif.Y1),       32'h00FA);
    chk("steer_y1_valid", 32'(bif.y1_valid), 32'd1);
    chk("steer_cnt1",     32'(bif.cnt1),     32'd1);
    chk("steer_y0_drain", 32'(bif.y0_valid), 32'd0);
    chk("steer_Y0_keep",  32'(bif.Y0),       32'h00AF);
    drive(1'b0, 1'b1, 16'hFFFF);
    step();
    chk("idle_cnt1",      32'(bif.cnt1),     32'd1);
    chk("idle_y1_drain",  32'(bif.y1_valid), 32'd0);

    // ---------------- stall on channel 0 ----------------
    bif.y0_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h1234);
    chk("stall_rdy_first", 32'(bif.in_ready), 32'd1);
    step();
    chk("stall_Y0_first", 32'(bif.Y0),   32'h1234);
    chk("stall_cnt0",     32'(bif.cnt0), 32'd2);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 16'h5678);
      chk("stall_rdy_s0", 32'(bif.in_ready), 32'd0);
      drive(1'b1, 1'b1, 16'hB000 + 16'(i));
      chk("stall_rdy_s1", 32'(bif.in_ready), 32'd1);
      step();
      chk("stall_Y0_hold", 32'(bif.Y0),       32'h1234);
      chk("stall_y0_vld",  32'(bif.y0_valid), 32'd1);
      chk("stall_Y1",      32'(bif.Y1),       32'hB000 + 32'(i));
    end
    chk("stall_cnt0_hold", 32'(bif.cnt0), 32'd2);
    chk("stall_cnt1",      32'(bif.cnt1), 32'd6);
    bif.y0_ready = 1'b1;
    drive(1'b1, 1'b0, 16'h5678);
    chk("unstall_rdy", 32'(bif.in_ready), 32'd1);
    step();
    chk("unstall_Y0",   32'(bif.Y0),       32'h5678);
    chk("unstall_vld",  32'(bif.y0_valid), 32'd1);
    chk("unstall_cnt0", 32'(bif.cnt0),     32'd3);
    drive(1'b0, 1'b0, 16'h0);
    step();
    chk("unstall_drain", 32'(bif.y0_valid), 32'd0);

    // ---------------- simultaneous drain and load ----------------
    bif.y1_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, 16'(k));
      chk("stream_rdy", 32'(bif.in_ready), 32'd1);
      step();
      chk("stream_vld", 32'(bif.y1_valid), 32'd1);
      chk("stream_Y1",  32'(bif.Y1),       32'(k));
    end
    chk("stream_cnt1", 32'(bif.cnt1), 32'd10);
    drive(1'b0, 1'b1, 16'h0);
    step();

    // ---------------- counter wrap on channel 0 ----------------
    // cnt0 starts at 3, so it reaches 255 after 252 accepts and wraps to 0
    // on the 253rd accept.
    bif.y0_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      drive(1'b1, 1'b0, 16'(i));
      step();
      if (i == 252) chk("wrap_cnt0_255", 32'(bif.cnt0), 32'd255);
      if (i == 253) chk("wrap_cnt0_0",   32'(bif.cnt0), 32'd0);
    end
    chk("wrap_cnt0_end", 32'(bif.cnt0), 32'd3);
    chk("wrap_cnt1",     32'(bif.cnt1), 32'd10);
    chk("wrap_Y0_last",  32'(bif.Y0),   32'h0100);
    drive(1'b0, 1'b0, 16'h0);
    step();

    // ---------------- reset mid-operation ----------------
    bif.y0_ready = 1'b0;
    bif.y1_ready = 1'b0;
    drive(1'b1, 1'b0, 16'hAAAA);
    step();
    drive(1'b1, 1'b1, 16'h5555);
    step();
    chk("mid_y0_full", 32'(bif.y0_valid), 32'd1);
    chk("mid_y1_full", 32'(bif.y1_valid), 32'd1);
    drive(1'b0, 1'b0, 16'h0);
    rst          = 1'b1;
    bif.y0_ready = 1'b1;
    #1;
    chk("mid_rdy_in_rst", 32'(bif.in_ready), 32'd0);
    step();
    rst          = 1'b0;
    bif.y0_ready = 1'b0;
    #1;
    chk("mid_y0_valid", 32'(bif.y0_valid), 32'd0);
    chk("mid_y1_valid", 32'(bif.y1_valid), 32'd0);
    chk("mid_Y0",       32'(bif.Y0),       32'h0);
    chk("mid_Y1",       32'(bif.Y1),       32'h0);
    chk("mid_cnt0",     32'(bif.cnt0),     32'd0);
    chk("mid_cnt1",     32'(bif.cnt1),     32'd0);
    chk("mid_rdy_after", 32'(bif.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
